// File: rtl/temp_bcd_converter.sv
// Binary temperature to three-digit BCD converter.
// A sequential double-dabble engine handles one input bit per clock. Readings
// above MAX_VALUE are clamped and flagged. Leading zeros can optionally be
// replaced by a blank font code so the display shows "  0" instead of "000".
module temp_bcd_converter #(
    parameter int          IN_WIDTH      = 10,
    parameter int          MAX_VALUE     = 999,
    parameter bit          BLANK_LEADING = 1'b1,
    parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] temp_raw,
    input  logic                temp_valid,
    output logic                temp_ready,
    output logic [3:0]          temp_value_100,
    output logic [3:0]          temp_value_10,
    output logic [3:0]          temp_value_1,
    output logic                conv_done,
    output logic                temp_sat
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH);
    localparam logic [31:0] MAX_U32 = 32'(MAX_VALUE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [IN_WIDTH-1:0] bin_reg;
    logic [11:0]         bcd_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                sat_pend_reg;

    logic [11:0]             bcd_adj;
    logic [IN_WIDTH+11:0]    shifted;
    logic                    sample_sat;
    logic [IN_WIDTH-1:0]     sample_clamped;
    logic [3:0]              dig_h;
    logic [3:0]              dig_t;
    logic [3:0]              dig_o;
    logic [3:0]              disp_h;
    logic [3:0]              disp_t;

    // Add-3 correction on every BCD nibble that would overflow when doubled.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? bcd_reg[gi*4 +: 4] + 4'd3
                                        : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Corrected nibbles and remaining binary bits shift together.
    assign shifted = {bcd_adj, bin_reg} << 1;

    // Compare at 32 bits so narrow inputs never falsely wrap against the ceiling.
    assign sample_sat     = {{(32-IN_WIDTH){1'b0}}, temp_raw} > MAX_U32;
    assign sample_clamped = sample_sat ? MAX_U32[IN_WIDTH-1:0] : temp_raw;

    assign dig_h = bcd_reg[11:8];
    assign dig_t = bcd_reg[7:4];
    assign dig_o = bcd_reg[3:0];

    // Leading-zero suppression: tens blanks only when hundreds is also zero.
    assign disp_h = (BLANK_LEADING && (dig_h == 4'd0)) ? BLANK_CODE : dig_h;
    assign disp_t = (BLANK_LEADING && (dig_h == 4'd0) && (dig_t == 4'd0))
                    ? BLANK_CODE : dig_t;

    // Conversion FSM with registered handshake, digit and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bin_reg        <= '0;
            bcd_reg        <= '0;
            cnt_reg        <= '0;
            sat_pend_reg   <= 1'b0;
            temp_ready     <= 1'b1;
            temp_value_100 <= 4'h0;
            temp_value_10  <= 4'h0;
            temp_value_1   <= 4'h0;
            conv_done      <= 1'b0;
            temp_sat       <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (temp_valid && temp_ready) begin
                        bin_reg      <= sample_clamped;
                        bcd_reg      <= '0;
                        cnt_reg      <= CNT_LOAD;
                        sat_pend_reg <= sample_sat;
                        temp_ready   <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg <= shifted[IN_WIDTH+11:IN_WIDTH];
                    bin_reg <= shifted[IN_WIDTH-1:0];
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    temp_value_100 <= disp_h;
                    temp_value_10  <= disp_t;
                    temp_value_1   <= dig_o;
                    temp_sat       <= sat_pend_reg;
                    conv_done      <= 1'b1;
                    temp_ready     <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg  <= IDLE;
                    temp_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Scoreboard bench for temp_bcd_converter: a blanking instance and a raw
// (non-blanking) instance share the same stimulus; expectations are queued at
// accept time and checked by an independent monitor on each conv_done.
module tb_temp_bcd_converter;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] temp_raw;
    logic         temp_valid;
    logic         temp_ready,  conv_done,  temp_sat;
    logic [3:0]   d100, d10, d1;
    logic         nb_ready, nb_done, nb_sat;
    logic [3:0]   nb100, nb10, nb1;

    temp_bcd_converter #(.IN_WIDTH(W), .MAX_VALUE(999), .BLANK_LEADING(1'b1), .BLANK_CODE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .temp_raw(temp_raw), .temp_valid(temp_valid),
        .temp_ready(temp_ready), .temp_value_100(d100), .temp_value_10(d10),
        .temp_value_1(d1), .conv_done(conv_done), .temp_sat(temp_sat)
    );

    temp_bcd_converter #(.IN_WIDTH(W), .MAX_VALUE(999), .BLANK_LEADING(1'b0), .BLANK_CODE(4'hF)) dut_nb (
        .clk(clk), .rst_n(rst_n), .temp_raw(temp_raw), .temp_valid(temp_valid),
        .temp_ready(nb_ready), .temp_value_100(nb100), .temp_value_10(nb10),
        .temp_value_1(nb1), .conv_done(nb_done), .temp_sat(nb_sat)
    );

    typedef struct {
        int         value;
        logic [3:0] h, t, o;
        logic [3:0] rh, rt, ro;
        logic       sat;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop and compare on every conv_done, flag spurious pulses.
    always @(negedge clk) begin
        if (rst_n && (conv_done || nb_done)) begin
            check("done_agree", {31'b0, nb_done}, {31'b0, conv_done});
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", cyc, e.done_cyc);
                check("digits", {20'b0, d100, d10, d1}, {20'b0, e.h, e.t, e.o});
                check("raw_digits", {20'b0, nb100, nb10, nb1}, {20'b0, e.rh, e.rt, e.ro});
                check("sat", {31'b0, temp_sat}, {31'b0, e.sat});
                check("ready_after_done", {31'b0, temp_ready}, 32'd1);
                $display("txn value=%0d digits=%h/%h/%h raw=%h/%h/%h sat=%0b cycle=%0d",
                         e.value, d100, d10, d1, nb100, nb10, nb1, temp_sat, cyc);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (temp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Present one sample, wait for its accept edge and queue its expectation.
    task automatic send(input int v, input logic [3:0] h, t, o, rh, rt, ro, input logic s);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        temp_raw   = W'(v);
        temp_valid = 1'b1;
        @(negedge clk);
        e.value = v; e.h = h; e.t = t; e.o = o;
        e.rh = rh; e.rt = rt; e.ro = ro; e.sat = s;
        e.done_cyc = cyc + W + 1;
        sb.push_back(e);
        temp_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        bit   ok;
        exp_t e;
        rst_n      = 1'b0;
        temp_valid = 1'b0;
        temp_raw   = '0;

        // Reset with valid toggling: outputs must sit at reset values.
        for (int i = 0; i < 4; i++) begin
            temp_valid = ~temp_valid;
            temp_raw   = W'(123);
            @(negedge clk);
            check("reset_digits", {20'b0, d100, d10, d1}, 32'h000);
            check("reset_ready", {31'b0, temp_ready}, 32'd1);
            check("reset_done", {31'b0, conv_done}, 32'd0);
        end
        temp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with valid low: nothing may change.
        repeat (20) @(negedge clk);
        check("idle_digits", {20'b0, d100, d10, d1}, 32'h000);
        check("idle_sat", {31'b0, temp_sat}, 32'd0);
        check("idle_ready", {31'b0, temp_ready}, 32'd1);

        send(75,   4'hF, 4'h7, 4'h5, 4'h0, 4'h7, 4'h5, 1'b0);
        send(0,    4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        send(100,  4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        send(9,    4'hF, 4'hF, 4'h9, 4'h0, 4'h0, 4'h9, 1'b0);
        send(10,   4'hF, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
        send(1023, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 1'b1);
        send(999,  4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 1'b0);
        send(1000, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 1'b1);
        drain();

        // Valid held while busy: 512 must be taken only once ready returns.
        send(42, 4'hF, 4'h4, 4'h2, 4'h0, 4'h4, 4'h2, 1'b0);
        temp_raw   = W'(512);
        temp_valid = 1'b1;
        wait_ready(ok);
        if (ok) begin
            @(negedge clk);
            e.value = 512; e.h = 4'h5; e.t = 4'h1; e.o = 4'h2;
            e.rh = 4'h5; e.rt = 4'h1; e.ro = 4'h2; e.sat = 1'b0;
            e.done_cyc = cyc + W + 1;
            sb.push_back(e);
        end
        temp_valid = 1'b0;
        drain();

        // Reset in the middle of a conversion: abort, no conv_done.
        send(850, 4'h8, 4'h5, 4'h0, 4'h8, 4'h5, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_digits", {20'b0, d100, d10, d1}, 32'h000);
        check("abort_done", {31'b0, conv_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'b0, temp_ready}, 32'd1);
        repeat (15) @(negedge clk);
        check("abort_hold", {20'b0, d100, d10, d1}, 32'h000);

        send(37, 4'hF, 4'h3, 4'h7, 4'h0, 4'h3, 4'h7, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
